vec_id_tagger: RTL

Stream-side producer of vector IDs for the forwarding adder network. It accepts per-vector length descriptors and a stream of element payloads, then tags each element with an N-bit vector ID and a last-of-vector flag. Downstream ID comparators use these tags to decide reduction boundaries. IDs are assigned sequentially modulo 2^N, so any two adjacent vectors always carry different IDs.

---
 rtl/vec_id_tagger.sv | 71 +++++++
 1 files changed

// File: rtl/vec_id_tagger.sv
// vec_id_tagger: tags streamed elements with a sequential modulo-2^N vector ID
// and a last-of-vector flag, driven by per-vector length descriptors.
module vec_id_tagger #(
   parameter int N      = 3,
   parameter int LEN_W  = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              len_valid,
   output logic              len_ready,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [N-1:0]      out_id,
   output logic              out_last,
   output logic              busy
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t            r_state, w_next_state;
   logic [N-1:0]      r_cur_id;
   logic [LEN_W-1:0]  r_remaining;
   logic              r_out_valid, r_out_last;
   logic [DATA_W-1:0] r_out_data;
   logic [N-1:0]      r_out_id;
   logic              w_len_xfer, w_in_xfer, w_last, w_len_zero, w_id_inc;
   assign w_len_xfer = len_valid && len_ready;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_last     = r_remaining == LEN_W'(1);
   assign w_len_zero = len == '0;
   // An empty vector still consumes an ID so adjacent vectors never share one.
   assign w_id_inc   = (w_len_xfer && w_len_zero) || (w_in_xfer && w_last);
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_id     = r_out_id;
   assign out_last   = r_out_last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   always_comb
      w_next_state = (r_state == IDLE) ? ((w_len_xfer && !w_len_zero) ? ACTIVE : IDLE)
                                       : ((w_in_xfer && w_last) ? IDLE : ACTIVE);
   always_comb begin
      len_ready = r_state == IDLE;
      in_ready  = (r_state == ACTIVE) && (!r_out_valid || out_ready);
      busy      = r_state == ACTIVE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_cur_id    <= '0;
         r_remaining <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= '0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_id_inc) r_cur_id <= r_cur_id + 1'b1;
         if (w_len_xfer && !w_len_zero) r_remaining <= len;
         else if (w_in_xfer)            r_remaining <= r_remaining - 1'b1;
         if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_id    <= r_cur_id;
            r_out_last  <= w_last;
         end else if (out_ready) r_out_valid <= 1'b0;
      end
endmodule
